tm1638_responder: RTL and testbench
===================================

# tm1638_responder

Synthesizable responder for the TM1638 three-wire serial bus: STB, CLK and DIO, LSB-first. It sits on the device side of the bus that our TM1638 host controller drives, and behaves as the chip does. It decodes data, address and display-control commands and holds the 16-byte display RAM. On key-read frames it shifts out four key-scan bytes. It serves as an on-FPGA loopback target for host bring-up and as a drop-in chip model for system benches.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `stb`, `sclk` and `dio_in`; minimum 2.
- `clk` in 1: system clock; oversamples the bus.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stb` in 1: bus chip-select, active-low; asynchronous to `clk`.
- `sclk` in 1: bus clock from the host; asynchronous to `clk`.
- `dio_in` in 1: DIO value read from the pad.
- `dio_out` out 1: DIO value to drive on the pad.
- `dio_oe` out 1: pad output enable; 1 means drive `dio_out`.
- `key_scan` in 32: key matrix. Byte n is `key_scan[8n+7:8n]` and is sent as the n-th read byte.
- `disp_raddr` in 4: display RAM read address.
- `disp_rdata` out 8: combinational read of RAM[`disp_raddr`].
- `disp_on` out 1: display enable from the last display-control command.
- `brightness` out 3: pulse-width setting from the last display-control command.
- `ram_wr` out 1: one-cycle pulse for each display RAM byte written.

## Operation
- Front end: each bus input passes through `SYNC_STAGES` flops, then one more flop for edge detection. The edge detector produces pulses for `sclk` rise, `sclk` fall, `stb` fall and `stb` rise.
- Bit receive: on each `sclk` rise while `stb` is low, shift the synchronized `dio_in` into bit position `bitcnt`, LSB first. When the 8th bit arrives, the byte is complete and `bitcnt` wraps to 0.
- Frame FSM states: IDLE, CMD, WDATA, RDATA, IGNORE.
  - IDLE to CMD on `stb` fall; clear `bitcnt`.
  - In CMD, the first complete byte is decoded as follows:
    - `01xx_xFRR`: data command. Store `mode_fixed`=F. RR=10 sets `mode_read`=1 and moves to RDATA. Any other RR sets `mode_read`=0 and moves to IGNORE.
    - `11xx_AAAA`: address command. Set `addr`=AAAA and move to WDATA.
    - `10xx_ELLL`: display control. Set `disp_on`=E and `brightness`=LLL, then move to IGNORE.
    - `00xx_xxxx`: move to IGNORE.
  - WDATA: each complete byte is written to RAM[`addr`] and pulses `ram_wr`. If `mode_fixed`=0, `addr` increments modulo 16 (15 wraps to 0).
  - RDATA: on entry, latch `key_scan` into a 32-bit shift register.
    - On each `sclk` fall, set `dio_oe`=1 and drive the next bit LSB first: byte 0 bit 0 first, through byte 3 bit 7.
    - After 32 bits, keep driving 0.
    - RDATA ignores `dio_in`.
  - IGNORE: consume clocks and take no action.
  - Any state returns to IDLE on `stb` rise. A partial byte is discarded and `dio_oe` goes to 0 the same cycle.
- `mode_fixed`, `mode_read`, `addr`, `disp_on`, `brightness` and RAM persist across frames.

## Timing
- Reset values: RAM all 0x00, `addr`=0, `mode_fixed`=0, `mode_read`=0, `disp_on`=0, `brightness`=0, `dio_oe`=0, `dio_out`=0, `ram_wr`=0, FSM in IDLE, `bitcnt`=0.
- Bus-to-action latency: `SYNC_STAGES`+1 `clk` cycles from pad edge to the internal edge pulse.
  - A RAM write, `ram_wr` and the register updates occur one cycle after the 8th `sclk`-rise pulse.
  - `dio_out` and `dio_oe` update one cycle after the `sclk`-fall pulse.
- Bus constraints:
  - `sclk` high and low phases must each be at least `SYNC_STAGES`+3 `clk` cycles.
  - `stb` setup to the first `sclk` fall is at least the same.
  - Violations are unsupported.
- Simultaneous `stb` rise and `sclk` rise pulses in one cycle: the `stb` rise wins and the bit is dropped.
- `rst_n` asserted mid-frame clears everything immediately and releases DIO. After `rst_n` deasserts, the FSM waits for a fresh `stb` fall, even if `stb` is already low.
- `disp_rdata` is combinational from the RAM flops. A read and a write to the same address in the same cycle returns the old data.

## Structure
- `tm1638_pkg` holds constants shared with the host controller:
  - command prefixes `C_DATA`=2'b01, `C_DISP`=2'b10, `C_ADDR`=2'b11;
  - `C_WRITE`=8'h40, `C_READ`=8'h42, `C_DISP_FULL`=8'h8F, `C_ADDR0`=8'hC0;
  - the FSM state encoding.
- One sub-module, `tm1638_bus_sync`: synchronizer plus edge detector, instantiated once per bus input, with `SYNC_STAGES` passed through.
- RAM is 16x8 flops inside the top module; no memory macro.

## Test plan
- Auto-increment write: frame 0x40, then frame 0xC0 followed by bytes 0x06, 0x5B, …, 16 bytes total → RAM[0..15] match the sent bytes, and `ram_wr` pulses exactly 16 times.
- Fixed-address write with wrap:
  - frame 0x44, then frame 0xC5 with bytes 0x3F, 0x06 → RAM[5]=0x06, other entries unchanged;
  - frame 0x40, then frame 0xCF with bytes 0xAA, 0xBB → RAM[15]=0xAA, RAM[0]=0xBB.
- Display control: frame 0x8F → `disp_on`=1, `brightness`=7. Frame 0x83 → `disp_on`=0, `brightness`=3.
- Key read: `key_scan`=32'h0011_1001, frame 0x42 then 32 `sclk` cycles → host samples bytes 0x01, 0x10, 0x11, 0x00. `dio_oe` is 0 during the command byte, 1 from the first `sclk` fall after it, and 0 within `SYNC_STAGES`+2 cycles of `stb` rise.
- Abort: frame 0xC0, then 5 bits of 0xFF, then `stb` high → RAM[0] unchanged, no `ram_wr`, next frame decodes normally.
- Async reset mid-read: assert `rst_n` low during the 12th bit of a read → `dio_oe`=0 within the same cycle and all registers at reset values. The next frame after release succeeds.

Source files
------------

// File: rtl/tm1638_pkg.sv
// -----------------------------------------------------------------------------
// tm1638_pkg
// Constants shared between the TM1638 host controller and the device-side
// responder: command prefixes, the common command bytes, and the frame FSM
// state encoding used by tm1638_responder.
// -----------------------------------------------------------------------------
package tm1638_pkg;

  // Command class, taken from bits [7:6] of the first byte of a frame
  localparam logic [1:0] C_DATA = 2'b01;
  localparam logic [1:0] C_DISP = 2'b10;
  localparam logic [1:0] C_ADDR = 2'b11;

  // Read/write selector in bits [1:0] of a data command
  localparam logic [1:0] RR_READ = 2'b10;

  // Common complete command bytes
  localparam logic [7:0] C_WRITE     = 8'h40;
  localparam logic [7:0] C_READ      = 8'h42;
  localparam logic [7:0] C_DISP_FULL = 8'h8F;
  localparam logic [7:0] C_ADDR0     = 8'hC0;

  // Frame FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WDATA  = 3'd2,
    ST_RDATA  = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  // Command class of a received command byte
  function automatic logic [1:0] cmd_prefix(input logic [7:0] cmd);
    return cmd[7:6];
  endfunction

endpackage

// File: rtl/tm1638_bus_sync.sv
// -----------------------------------------------------------------------------
// tm1638_bus_sync
// Brings one asynchronous bus wire into the clk domain and detects its edges.
// The wire passes through SYNC_STAGES flops, then one more flop that holds the
// previous synchronized value. Edge pulses are registered, so a pad edge shows
// up as a one-cycle pulse SYNC_STAGES+1 clk cycles later.
//
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   din    in  1  raw bus wire
//   level  out 1  synchronized level, aligned with the edge pulses
//   rise   out 1  one-cycle pulse on a 0->1 transition
//   fall   out 1  one-cycle pulse on a 1->0 transition
//
// RST_VAL is the value the chain assumes during reset. A wire that is already
// at RST_VAL when reset releases produces no edge.
// -----------------------------------------------------------------------------
module tm1638_bus_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Synchronizer chain, previous-value flop and registered edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

  assign level = prev;

endmodule

// File: rtl/tm1638_responder.sv
// -----------------------------------------------------------------------------
// tm1638_responder
// Device-side model of a TM1638 on its three-wire serial bus (STB, CLK, DIO,
// LSB first). Decodes data, address and display-control commands, holds the
// 16-byte display RAM, and shifts out four key-scan bytes on read frames.
//
// Ports:
//   clk         in  1   system clock, oversamples the bus
//   rst_n       in  1   asynchronous active-low reset
//   stb         in  1   bus chip-select, active-low, asynchronous
//   sclk        in  1   bus clock from the host, asynchronous
//   dio_in      in  1   DIO pad input
//   dio_out     out 1   DIO pad output value
//   dio_oe      out 1   DIO pad output enable (1 = drive dio_out)
//   key_scan    in  32  key matrix, byte n sent as the n-th read byte
//   disp_raddr  in  4   display RAM read address
//   disp_rdata  out 8   combinational display RAM read data
//   disp_on     out 1   display enable from the last display-control command
//   brightness  out 3   pulse width from the last display-control command
//   ram_wr      out 1   one-cycle pulse per display RAM byte written
// -----------------------------------------------------------------------------
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        sclk,
  input  logic        dio_in,
  output logic        dio_out,
  output logic        dio_oe,
  input  logic [31:0] key_scan,
  input  logic [3:0]  disp_raddr,
  output logic [7:0]  disp_rdata,
  output logic        disp_on,
  output logic [2:0]  brightness,
  output logic        ram_wr
);

  // Synchronized bus events
  logic stb_level;
  logic stb_rise;
  logic stb_fall;
  logic sclk_level_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic dio_level;
  logic dio_rise_unused;
  logic dio_fall_unused;

  // Frame state
  state_t      state;
  logic [2:0]  bitcnt;
  logic [7:0]  rx_shift;
  logic [31:0] key_shift;
  logic [3:0]  addr;
  logic        mode_fixed;
  logic        mode_read;

  // Display RAM
  logic [7:0]  ram [16];

  // Receive-side decode
  logic        bit_take;
  logic        byte_done;
  logic [7:0]  rx_byte;
  logic        wr_en;

  // The stb chain resets low so that a strobe already held low when reset
  // releases does not look like a fresh frame start.
  tm1638_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sync_stb (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (stb),
    .level (stb_level),
    .rise  (stb_rise),
    .fall  (stb_fall)
  );

  tm1638_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  tm1638_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sync_dio (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (dio_in),
    .level (dio_level),
    .rise  (dio_rise_unused),
    .fall  (dio_fall_unused)
  );

  // Bit capture qualification, assembled byte and RAM write enable
  always_comb begin
    // A strobe rise in the same cycle as a clock rise wins: the bit is dropped.
    bit_take  = sclk_rise & ~stb_rise & ~stb_level & (state != ST_IDLE);
    byte_done = bit_take & (bitcnt == 3'd7);
    rx_byte   = rx_shift;
    rx_byte[bitcnt] = dio_level;
    wr_en     = byte_done & (state == ST_WDATA);
  end

  // Frame FSM, command decode, key shift-out and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bitcnt     <= 3'd0;
      rx_shift   <= 8'h00;
      key_shift  <= 32'h0000_0000;
      addr       <= 4'h0;
      mode_fixed <= 1'b0;
      mode_read  <= 1'b0;
      disp_on    <= 1'b0;
      brightness <= 3'd0;
      dio_oe     <= 1'b0;
      dio_out    <= 1'b0;
      ram_wr     <= 1'b0;
    end else begin
      ram_wr <= wr_en;
      if (stb_rise) begin
        // End of frame: drop any partial byte and release the pad.
        state   <= ST_IDLE;
        bitcnt  <= 3'd0;
        dio_oe  <= 1'b0;
        dio_out <= 1'b0;
      end else begin
        if (bit_take) begin
          rx_shift <= rx_byte;
          bitcnt   <= bitcnt + 3'd1;
        end
        case (state)
          ST_IDLE: begin
            if (stb_fall) begin
              state  <= ST_CMD;
              bitcnt <= 3'd0;
            end
          end
          ST_CMD: begin
            if (byte_done) begin
              case (cmd_prefix(rx_byte))
                C_DATA: begin
                  mode_fixed <= rx_byte[2];
                  if (rx_byte[1:0] == RR_READ) begin
                    mode_read <= 1'b1;
                    key_shift <= key_scan;
                    state     <= ST_RDATA;
                  end else begin
                    mode_read <= 1'b0;
                    state     <= ST_IGNORE;
                  end
                end
                C_ADDR: begin
                  addr  <= rx_byte[3:0];
                  state <= ST_WDATA;
                end
                C_DISP: begin
                  disp_on    <= rx_byte[3];
                  brightness <= rx_byte[2:0];
                  state      <= ST_IGNORE;
                end
                default: begin
                  state <= ST_IGNORE;
                end
              endcase
            end
          end
          ST_WDATA: begin
            // 4-bit address wraps 15 -> 0 on its own.
            if (byte_done && !mode_fixed) begin
              addr <= addr + 4'd1;
            end
          end
          ST_RDATA: begin
            // Zeros shift in behind the key bytes, so after 32 bits DIO reads 0.
            if (sclk_fall) begin
              dio_oe    <= 1'b1;
              dio_out   <= key_shift[0];
              key_shift <= {1'b0, key_shift[31:1]};
            end
          end
          ST_IGNORE: begin
            state <= ST_IGNORE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Display RAM storage; write lands one cycle after the 8th clock-rise pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        ram[i] <= 8'h00;
      end
    end else if (wr_en) begin
      ram[addr] <= rx_byte;
    end
  end

  // Reads see the flop contents, so a same-cycle write returns the old byte.
  assign disp_rdata = ram[disp_raddr];

  // mode_read has no consumer inside this block; it is kept as chip state.
  logic unused_state;
  assign unused_state = &{1'b0, mode_read, sclk_level_unused, dio_rise_unused, dio_fall_unused};

endmodule

// File: tb/tb_tm1638_responder.sv
`timescale 1ns/1ps
module tb_tm1638_responder;
  import tm1638_pkg::*;

  localparam int SS = 2;   // synchronizer depth
  localparam int HP = 8;   // bus half period in clk cycles (>= SS+3)

  localparam int K_RAM   = 0;
  localparam int K_DISP  = 1;
  localparam int K_OBS   = 2;
  localparam int K_RD    = 3;
  localparam int K_WRCNT = 4;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] a;
    logic [31:0] v;
  } probe_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b1;
  logic        sclk = 1'b1;
  logic        dio_in = 1'b1;
  logic        dio_out;
  logic        dio_oe;
  logic [31:0] key_scan = 32'h0;
  logic [3:0]  disp_raddr = 4'h0;
  logic [7:0]  disp_rdata;
  logic        disp_on;
  logic [2:0]  brightness;
  logic        ram_wr;

  always #5 clk = ~clk;

  tm1638_responder #(.SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stb        (stb),
    .sclk       (sclk),
    .dio_in     (dio_in),
    .dio_out    (dio_out),
    .dio_oe     (dio_oe),
    .key_scan   (key_scan),
    .disp_raddr (disp_raddr),
    .disp_rdata (disp_rdata),
    .disp_on    (disp_on),
    .brightness (brightness),
    .ram_wr     (ram_wr)
  );

  // Scoreboard queues
  probe_t      probe_q[$];
  logic [11:0] wr_q[$];      // {addr, data} of each expected RAM write
  logic [7:0]  rd_exp_q[$];  // expected key bytes on DIO
  logic [7:0]  fq[$];        // bytes of the next write frame
  int n_cmp = 0;
  int n_bad = 0;
  int wr_seen = 0;

  // Reference model of chip-visible state
  logic [7:0] m_ram [16];
  logic [3:0] m_addr;
  logic       m_fixed;
  logic       m_on;
  logic [2:0] m_bri;
  int         m_wr_total = 0;

  logic [7:0] seg [16] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F,
                           8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares whenever the DUT writes or a probe is pending
  always @(negedge clk) begin
    if (ram_wr) begin
      logic [11:0] w;
      wr_seen++;
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ram_wr: got a write pulse, required none");
      end else begin
        w = wr_q.pop_front();
        disp_raddr = w[11:8];
        #1;
        check($sformatf("ram_wr_data[%0d]", w[11:8]), {24'h0, disp_rdata}, {24'h0, w[7:0]});
      end
    end else if (probe_q.size() > 0) begin
      probe_t p;
      p = probe_q.pop_front();
      case (p.kind)
        K_RAM: begin
          disp_raddr = p.a[3:0];
          #1;
          check($sformatf("%s[%0d]", p.name, p.a), {24'h0, disp_rdata}, p.v);
        end
        K_DISP:  check(p.name, {28'h0, disp_on, brightness}, p.v);
        K_OBS:   check(p.name, p.a, p.v);
        K_WRCNT: check(p.name, wr_seen, p.v);
        K_RD: begin
          if (rd_exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got 0x%0h, required no byte", p.name, p.a);
          end else begin
            check(p.name, p.a, {24'h0, rd_exp_q.pop_front()});
          end
        end
        default: ;
      endcase
    end
  end

  task automatic push_probe(input int kind, input string name, input logic [31:0] a, input logic [31:0] v);
    probe_t p;
    p.kind = kind;
    p.name = name;
    p.a    = a;
    p.v    = v;
    probe_q.push_back(p);
  endtask

  task automatic obs(input string name, input logic [31:0] act, input logic [31:0] exp);
    push_probe(K_OBS, name, act, exp);
  endtask

  task automatic probe_ram_all();
    for (int i = 0; i < 16; i++) push_probe(K_RAM, "ram", i, {24'h0, m_ram[i]});
  endtask

  task automatic probe_disp(input string name);
    push_probe(K_DISP, name, 32'h0, {28'h0, m_on, m_bri});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_addr  = 4'h0;
    m_fixed = 1'b0;
    m_on    = 1'b0;
    m_bri   = 3'd0;
  endtask

  // Frame-level model of a host write/command frame held in fq
  task automatic model_write();
    logic [7:0] c;
    if (fq.size() == 0) return;
    c = fq[0];
    case (c[7:6])
      2'b01: m_fixed = c[2];
      2'b10: begin m_on = c[3]; m_bri = c[2:0]; end
      2'b11: begin
        m_addr = c[3:0];
        for (int i = 1; i < fq.size(); i++) begin
          m_ram[m_addr] = fq[i];
          wr_q.push_back({m_addr, fq[i]});
          m_wr_total++;
          if (!m_fixed) m_addr = 4'((int'(m_addr) + 1) % 16);
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((probe_q.size() > 0 || wr_q.size() > 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    tick(2);
    if (probe_q.size() > 0 || wr_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d probes, %0d writes pending, required 0", probe_q.size(), wr_q.size());
      probe_q.delete();
      wr_q.delete();
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input bit chk_oe);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      dio_in = b[i];
      tick(HP);
      if (chk_oe) obs("oe_low_during_cmd", {31'h0, dio_oe}, 32'h0);
      sclk = 1'b1;
      tick(HP);
    end
  endtask

  task automatic read_byte(output logic [7:0] r, input bit first);
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0;
      dio_in = 1'b1;
      tick(HP);
      if (first && i == 0) obs("oe_high_after_cmd", {31'h0, dio_oe}, 32'h1);
      r[i] = dio_oe ? dio_out : 1'b1;
      sclk = 1'b1;
      tick(HP);
    end
  endtask

  task automatic write_frame();
    model_write();
    stb = 1'b0;
    tick(HP);
    foreach (fq[i]) send_bits(fq[i], 8, 1'b0);
    stb = 1'b1;
    tick(HP);
  endtask

  task automatic read_frame(input logic [7:0] cmd, input int nb);
    logic [7:0] r;
    m_fixed = cmd[2];
    for (int i = 0; i < nb; i++) rd_exp_q.push_back(i < 4 ? key_scan[8*i +: 8] : 8'h00);
    stb = 1'b0;
    tick(HP);
    send_bits(cmd, 8, 1'b1);
    for (int i = 0; i < nb; i++) begin
      read_byte(r, i == 0);
      push_probe(K_RD, "key_byte", {24'h0, r}, 32'h0);
    end
    stb = 1'b1;
    tick(SS + 2);
    obs("oe_released_after_stb", {31'h0, dio_oe}, 32'h0);
    tick(HP);
  endtask

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    model_reset();
    tick(4);
    rst_n = 1'b1;
    tick(4);

    // Reset state
    obs("dio_oe_reset", {31'h0, dio_oe}, 32'h0);
    obs("dio_out_reset", {31'h0, dio_out}, 32'h0);
    obs("ram_wr_reset", {31'h0, ram_wr}, 32'h0);
    probe_disp("disp_reset");
    probe_ram_all();
    drain();

    // Auto-increment write of 16 bytes
    fq.delete(); fq.push_back(C_WRITE); write_frame();
    fq.delete(); fq.push_back(C_ADDR0);
    for (int i = 0; i < 16; i++) fq.push_back(seg[i]);
    write_frame();
    drain();
    probe_ram_all();
    push_probe(K_WRCNT, "ram_wr_count_auto", 32'h0, m_wr_total);
    drain();

    // Fixed-address write, then auto-increment wrap 15 -> 0
    fq.delete(); fq.push_back(8'h44); write_frame();
    fq.delete(); fq.push_back(8'hC5); fq.push_back(8'h3F); fq.push_back(8'h06); write_frame();
    drain();
    probe_ram_all();
    drain();
    fq.delete(); fq.push_back(C_WRITE); write_frame();
    fq.delete(); fq.push_back(8'hCF); fq.push_back(8'hAA); fq.push_back(8'hBB); write_frame();
    drain();
    probe_ram_all();
    drain();

    // Display control
    fq.delete(); fq.push_back(C_DISP_FULL); write_frame();
    probe_disp("disp_full");
    drain();
    fq.delete(); fq.push_back(8'h83); write_frame();
    probe_disp("disp_83");
    drain();

    // Key read
    key_scan = 32'h0011_1001;
    read_frame(C_READ, 4);
    drain();

    // Abort mid-byte: no write, next frame decodes normally
    fq.delete(); fq.push_back(C_ADDR0); model_write();
    stb = 1'b0;
    tick(HP);
    send_bits(C_ADDR0, 8, 1'b0);
    send_bits(8'hFF, 5, 1'b0);
    stb = 1'b1;
    tick(HP);
    probe_ram_all();
    push_probe(K_WRCNT, "ram_wr_count_abort", 32'h0, m_wr_total);
    drain();
    fq.delete(); fq.push_back(8'h8A); write_frame();
    probe_disp("disp_after_abort");
    drain();

    // Asynchronous reset during the 12th bit of a read
    key_scan = 32'hA5C3_5A3C;
    m_fixed = 1'b1;
    rd_exp_q.push_back(key_scan[7:0]);
    stb = 1'b0;
    tick(HP);
    send_bits(8'h46, 8, 1'b1);
    read_byte(r, 1'b1);
    push_probe(K_RD, "key_byte_before_reset", {24'h0, r}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b0; tick(HP); sclk = 1'b1; tick(HP);
    end
    sclk = 1'b0;
    tick(SS + 3);
    obs("oe_before_reset", {31'h0, dio_oe}, 32'h1);
    rst_n = 1'b0;
    #1;
    obs("oe_in_reset", {31'h0, dio_oe}, 32'h0);
    obs("dio_out_in_reset", {31'h0, dio_out}, 32'h0);
    model_reset();
    tick(3);
    probe_ram_all();
    probe_disp("disp_in_reset");
    drain();
    sclk = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    // Strobe still low after release: these bits must not form a frame
    send_bits(C_DISP_FULL, 8, 1'b0);
    stb = 1'b1;
    tick(HP);
    probe_disp("disp_no_stale_frame");
    drain();
    // Mode register was reset, so this write auto-increments
    fq.delete(); fq.push_back(8'hC3); fq.push_back(8'h12); fq.push_back(8'h34); write_frame();
    drain();
    probe_ram_all();
    drain();

    // Randomized frames
    for (int it = 0; it < 30; it++) begin
      int sel;
      logic [7:0] c;
      logic [1:0] rr;
      sel = $urandom_range(0, 4);
      case (sel)
        0: begin
          c = {2'b11, 2'($urandom), 4'($urandom)};
          fq.delete(); fq.push_back(c);
          for (int k = 0; k < $urandom_range(0, 4); k++) fq.push_back(8'($urandom));
          write_frame();
        end
        1: begin
          rr = 2'($urandom_range(0, 2));
          if (rr == 2'b10) rr = 2'b11;
          c = {2'b01, 3'($urandom), 1'($urandom), rr};
          fq.delete(); fq.push_back(c); write_frame();
        end
        2: begin
          c = {2'b10, 2'($urandom), 1'($urandom), 3'($urandom)};
          fq.delete(); fq.push_back(c); write_frame();
        end
        3: begin
          key_scan = $urandom;
          c = {2'b01, 3'($urandom), 1'($urandom), 2'b10};
          read_frame(c, $urandom_range(1, 5));
        end
        default: begin
          c = {2'b11, 2'($urandom), 4'($urandom)};
          fq.delete(); fq.push_back(c); model_write();
          stb = 1'b0;
          tick(HP);
          send_bits(c, 8, 1'b0);
          send_bits(8'($urandom), $urandom_range(1, 7), 1'b0);
          stb = 1'b1;
          tick(HP);
        end
      endcase
      drain();
      if (it % 5 == 4) begin
        probe_ram_all();
        probe_disp("disp_random");
        push_probe(K_WRCNT, "ram_wr_count_random", 32'h0, m_wr_total);
        drain();
      end
    end

    drain();
    n_cmp++;
    if (rd_exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL key_bytes_missing: %0d expected bytes not read, required 0", rd_exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
